// File: rtl/ifq_pkg.sv
// Shared widths and queue entry layout for the
// instruction fetch queue.
package ifq_pkg;

    localparam int IFQ_DATA_W = 32;
    localparam int IFQ_ADDR_W = 10;
    localparam int IFQ_DEPTH  = 4;

    typedef struct packed {
        logic [IFQ_DATA_W-1:0] instr;
        logic [IFQ_ADDR_W-1:0] pc;
    } ifqEntry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Prefetch queue between the fetch memory and decode.
// Flush empties it in one edge.
module ifq_fifo #(
    parameter int W     = 42,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             pushData,
    input  logic                     pop,
    input  logic                     flush,
    output logic [W-1:0]             head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  store [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          full;
    logic          doPush;
    logic          doPop;

    assign valid  = (level != '0);
    assign full   = (level == LW'(DEPTH));
    assign doPop  = pop & valid;
    assign doPush = push & (~full | doPop);
    assign head   = store[rdPtr];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            level <= level + LW'(doPush) - LW'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) store[wrPtr] <= pushData;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: PC generation, synchronous instruction
// memory with debug loader, and prefetch queue toward ID.
module instr_fetch_queue
    import ifq_pkg::*;
#(
    parameter int DATA_W = IFQ_DATA_W,
    parameter int ADDR_W = IFQ_ADDR_W,
    parameter int DEPTH  = IFQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_redirect,
    input  logic [ADDR_W-1:0]          in_redirect_pc,
    input  logic                       in_halt,
    input  logic                       in_ld_en,
    input  logic [DATA_W-1:0]          in_ld_data,
    output logic                       out_valid,
    input  logic                       in_ready,
    output logic [DATA_W-1:0]          out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]     out_level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = LW + 1;
    localparam int EW = DATA_W + ADDR_W;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdData;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ldAddr;
    logic [ADDR_W-1:0] tag;
    logic              inflight;
    logic              issue;
    logic              pop;
    logic              qValid;
    logic [LW-1:0]     qLevel;
    logic [EW-1:0]     qHead;
    logic [CW-1:0]     occ;
    logic [CW-1:0]     room;
    logic [DATA_W-1:0] holdInstr;
    logic [ADDR_W-1:0] holdPc;

    assign pop  = qValid & in_ready;
    assign occ  = CW'(qLevel) + CW'(inflight);
    assign room = CW'(DEPTH) + CW'(pop);

    // Count the pending return so the queue can never overflow.
    assign issue = rst && !in_redirect && !in_halt
                && !in_ld_en && (occ < room);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc       <= '0;
            ldAddr   <= '0;
            tag      <= '0;
            inflight <= 1'b0;
        end else begin
            if (in_ld_en) ldAddr <= ldAddr + ADDR_W'(1);
            if (in_redirect) begin
                pc       <= in_redirect_pc;
                inflight <= 1'b0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc  <= pc + ADDR_W'(1);
                    tag <= pc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && in_ld_en) mem[ldAddr] <= in_ld_data;
        if (issue) rdData <= mem[pc];
    end

    ifq_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight & ~in_redirect),
        .pushData ({rdData, tag}),
        .pop      (pop),
        .flush    (in_redirect),
        .head     (qHead),
        .valid    (qValid),
        .level    (qLevel)
    );

    // An empty queue keeps showing the last head seen by ID.
    always_ff @(posedge clk) begin
        if (!rst) begin
            holdInstr <= '0;
            holdPc    <= '0;
        end else if (qValid) begin
            holdInstr <= qHead[EW-1:ADDR_W];
            holdPc    <= qHead[ADDR_W-1:0];
        end
    end

    assign out_valid = qValid;
    assign out_level = qLevel;
    assign out_instr = qValid ? qHead[EW-1:ADDR_W] : holdInstr;
    assign out_pc    = qValid ? qHead[ADDR_W-1:0]  : holdPc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vectors, corner
// sequences and random traffic against a queue-level model.
module tb_instr_fetch_queue;
    import ifq_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inRedirect = 1'b0;
    logic [AW-1:0] inRedirectPc = '0;
    logic          inHalt = 1'b0;
    logic          inLdEn = 1'b0;
    logic [DW-1:0] inLdData = '0;
    logic          inReady = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [2:0]    out_level;

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_redirect    (inRedirect),
        .in_redirect_pc (inRedirectPc),
        .in_halt        (inHalt),
        .in_ld_en       (inLdEn),
        .in_ld_data     (inLdData),
        .out_valid      (out_valid),
        .in_ready       (inReady),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_level      (out_level)
    );

    int checks = 0;
    int errors = 0;

    // Model: a memory, a queue of fetched words, at most one
    // pending read, and the last head shown to ID.
    ifqEntry_t     mq[$];
    ifqEntry_t     mpend[$];
    logic [DW-1:0] mmem [1 << AW];
    logic [AW-1:0] mpc;
    logic [AW-1:0] mld;
    logic [AW-1:0] mlastP;
    logic [DW-1:0] mlastI;

    task automatic modelEdge();
        bit pop;
        ifqEntry_t e;
        pop = (mq.size() != 0) && inReady;
        if (!rst) begin
            mq.delete();
            mpend.delete();
            mpc = '0;
            mld = '0;
            mlastP = '0;
            mlastI = '0;
        end else begin
            if (inLdEn) begin
                mmem[mld] = inLdData;
                mld = mld + 1'b1;
            end
            if (inRedirect) begin
                mq.delete();
                mpend.delete();
                mpc = inRedirectPc;
            end else begin
                if (pop) void'(mq.pop_front());
                if (mpend.size() != 0) mq.push_back(mpend.pop_front());
                if (!inHalt && !inLdEn && mq.size() < DEPTH) begin
                    e.instr = mmem[mpc];
                    e.pc = mpc;
                    mpend.push_back(e);
                    mpc = mpc + 1'b1;
                end
            end
            if (mq.size() != 0) begin
                mlastI = mq[0].instr;
                mlastP = mq[0].pc;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmpModel(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(mq.size() != 0));
        chk({tag, "_level"}, 64'(out_level), 64'(mq.size()));
        chk({tag, "_pc"}, 64'(out_pc), 64'(mlastP));
        chk({tag, "_instr"}, 64'(out_instr), 64'(mlastI));
    endtask

    typedef struct {
        bit            r;
        bit            ld;
        logic [DW-1:0] d;
        bit            rdy;
        bit            eV;
        logic [AW-1:0] ePc;
        logic [DW-1:0] eI;
        logic [2:0]    eL;
    } vec_t;

    vec_t vecs[18];

    initial begin
        bit found;

        vecs[0] = '{0, 0, 0, 1, 0, 0, 0, 0};
        for (int i = 0; i < 8; i++)
            vecs[1+i] = '{1, 1, 32'h100 + i, 1, 0, 0, 0, 0};
        vecs[9] = '{1, 0, 0, 1, 0, 0, 0, 0};
        for (int k = 0; k < 8; k++)
            vecs[10+k] = '{1, 0, 0, 1, 1, AW'(k), 32'h100 + k, 1};

        for (int i = 0; i < 18; i++) begin
            rst = vecs[i].r;
            inLdEn = vecs[i].ld;
            inLdData = vecs[i].d;
            inReady = vecs[i].rdy;
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].eV));
            chk($sformatf("vec%0d_level", i), 64'(out_level), 64'(vecs[i].eL));
            chk($sformatf("vec%0d_pc", i), 64'(out_pc), 64'(vecs[i].ePc));
            chk($sformatf("vec%0d_instr", i), 64'(out_instr), 64'(vecs[i].eI));
        end

        // Reset, then fill the whole memory so every fetch is known.
        rst = 1'b0;
        inLdEn = 1'b0;
        tick();
        cmpModel("rst2");
        rst = 1'b1;
        inReady = 1'b0;
        inLdEn = 1'b1;
        for (int i = 0; i < (1 << AW); i++) begin
            inLdData = $urandom;
            tick();
            cmpModel("load");
        end
        inLdEn = 1'b0;

        for (int i = 0; i < 8; i++) begin
            tick();
            cmpModel("sat");
        end
        chk("sat_level", 64'(out_level), 64'd4);
        chk("sat_head", 64'(out_pc), 64'd0);

        inReady = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            cmpModel("resume");
            chk($sformatf("resume_pc%0d", k), 64'(out_pc), 64'(k + 1));
        end

        inReady = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            cmpModel("refill");
        end
        inRedirect = 1'b1;
        inRedirectPc = 10'h3F0;
        tick();
        cmpModel("redir");
        chk("redir_valid", 64'(out_valid), 64'd0);
        inRedirect = 1'b0;
        tick();
        chk("redir_r1_valid", 64'(out_valid), 64'd0);
        tick();
        chk("redir_r2_valid", 64'(out_valid), 64'd1);
        chk("redir_r2_pc", 64'(out_pc), 64'h3F0);
        inReady = 1'b1;
        tick();
        chk("redir_r3_pc", 64'(out_pc), 64'h3F1);

        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            cmpModel("wrap");
            if (out_valid && out_pc == 10'h3FF) found = 1'b1;
        end
        chk("wrap_seen", 64'(found), 64'd1);
        tick();
        chk("wrap_pc", 64'(out_pc), 64'd0);

        inReady = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            cmpModel("fill3");
            if (out_level == 3'd3) found = 1'b1;
        end
        chk("fill3_seen", 64'(found), 64'd1);
        rst = 1'b0;
        tick();
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_level", 64'(out_level), 64'd0);
        rst = 1'b1;
        inReady = 1'b1;
        tick();
        tick();
        chk("restart_valid", 64'(out_valid), 64'd1);
        chk("restart_pc", 64'(out_pc), 64'd0);
        tick();
        cmpModel("run");

        inRedirect = 1'b1;
        inRedirectPc = 10'h155;
        tick();
        chk("redpop_valid", 64'(out_valid), 64'd0);
        inRedirect = 1'b0;
        tick();
        tick();
        chk("redpop_pc", 64'(out_pc), 64'h155);

        inHalt = 1'b1;
        tick();
        chk("halt_valid", 64'(out_valid), 64'd1);
        chk("halt_pc", 64'(out_pc), 64'h156);
        tick();
        chk("halt_drain", 64'(out_valid), 64'd0);
        tick();
        chk("halt_level", 64'(out_level), 64'd0);
        cmpModel("halt");
        inHalt = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            inRedirect = ($urandom_range(0, 19) == 0);
            inRedirectPc = AW'($urandom);
            inHalt = ($urandom_range(0, 9) == 0);
            inLdEn = ($urandom_range(0, 19) == 0);
            inLdData = $urandom;
            inReady = ($urandom_range(0, 9) < 7);
            tick();
            cmpModel("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
